// File: rtl/iomem_quad_encoder.sv
// N-channel 4x quadrature encoder counter on the PicoSoC iomem bus.
// One 256-byte window: CTRL, STATUS (W1C), IRQ_EN, SNAP, COUNT[ch], SNAPSHOT[ch].
module iomem_quad_encoder #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter logic [23:0] BASE_ADDR   = 24'h030003,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  input  logic [NUM_CH-1:0] enc_a,
  input  logic [NUM_CH-1:0] enc_b,
  output logic              irq
);

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_a_q, sync_a_d;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_b_q, sync_b_d;
  logic [NUM_CH-1:0] prev_a_q, prev_a_d, prev_b_q, prev_b_d;
  logic [NUM_CH-1:0] en_q, en_d, inv_q, inv_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d, unf_q, unf_d, err_q, err_d;
  logic [NUM_CH-1:0] ie_ovf_q, ie_ovf_d, ie_unf_q, ie_unf_d, ie_err_q, ie_err_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] count_q, count_d, snap_q, snap_d;
  logic              ready_q, ready_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              irq_q, irq_d;

  logic [NUM_CH-1:0] cur_a, cur_b;
  logic [NUM_CH-1:0] step_up, step_dn, step_err;
  logic [NUM_CH-1:0] ovf_set, unf_set, err_set;
  logic [NUM_CH-1:0] ovf_clr, unf_clr, err_clr;
  logic              hit, wr;
  logic [5:0]        word;
  logic [31:0]       wmask, rd_val, cnt_wr;
  logic [1:0]        unused_addr;

  assign cur_a       = sync_a_q[SYNC_STAGES-1];
  assign cur_b       = sync_b_q[SYNC_STAGES-1];
  assign word        = iomem_addr[7:2];
  assign unused_addr = iomem_addr[1:0];
  assign hit         = iomem_valid && !ready_q && (iomem_addr[31:8] == BASE_ADDR);
  assign wr          = hit && (iomem_wstrb != 4'b0000);
  assign wmask       = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                        {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};

  // Key is {prev A, prev B, cur A, cur B}; a disabled channel produces no event at all
  always_comb begin
    step_up  = '0;
    step_dn  = '0;
    step_err = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (en_q[c]) begin
        case ({prev_a_q[c], prev_b_q[c], cur_a[c], cur_b[c]})
          4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
            step_up[c] = ~inv_q[c];
            step_dn[c] = inv_q[c];
          end
          4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
            step_up[c] = inv_q[c];
            step_dn[c] = ~inv_q[c];
          end
          4'b0011, 4'b1100, 4'b0110, 4'b1001: step_err[c] = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (word)
      6'd0: begin
        rd_val[NUM_CH-1:0]  = en_q;
        rd_val[8 +: NUM_CH] = inv_q;
      end
      6'd1: begin
        rd_val[NUM_CH-1:0]   = ovf_q;
        rd_val[8 +: NUM_CH]  = unf_q;
        rd_val[16 +: NUM_CH] = err_q;
      end
      6'd2: begin
        rd_val[NUM_CH-1:0]   = ie_ovf_q;
        rd_val[8 +: NUM_CH]  = ie_unf_q;
        rd_val[16 +: NUM_CH] = ie_err_q;
      end
      default: begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (32'(word) == 4 + c)  rd_val[CNT_WIDTH-1:0] = count_q[c];
          if (32'(word) == 12 + c) rd_val[CNT_WIDTH-1:0] = snap_q[c];
        end
      end
    endcase
  end

  always_comb begin
    sync_a_d = {sync_a_q[SYNC_STAGES-2:0], enc_a};
    sync_b_d = {sync_b_q[SYNC_STAGES-2:0], enc_b};
    prev_a_d = cur_a;
    prev_b_d = cur_b;
    en_d     = en_q;
    inv_d    = inv_q;
    ie_ovf_d = ie_ovf_q;
    ie_unf_d = ie_unf_q;
    ie_err_d = ie_err_q;
    count_d  = count_q;
    snap_d   = snap_q;
    ready_d  = 1'b0;
    rdata_d  = '0;
    ovf_set  = '0;
    unf_set  = '0;
    err_set  = step_err;
    ovf_clr  = '0;
    unf_clr  = '0;
    err_clr  = '0;
    cnt_wr   = '0;

    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (step_up[c]) begin
        count_d[c] = count_q[c] + CNT_WIDTH'(1);
        ovf_set[c] = &count_q[c];
      end else if (step_dn[c]) begin
        count_d[c] = count_q[c] - CNT_WIDTH'(1);
        unf_set[c] = ~|count_q[c];
      end
    end

    if (hit) begin
      ready_d = 1'b1;
      rdata_d = rd_val;
    end

    if (wr) begin
      case (word)
        6'd0: begin
          if (iomem_wstrb[0]) en_d  = iomem_wdata[NUM_CH-1:0];
          if (iomem_wstrb[1]) inv_d = iomem_wdata[8 +: NUM_CH];
        end
        6'd1: begin
          if (iomem_wstrb[0]) ovf_clr = iomem_wdata[NUM_CH-1:0];
          if (iomem_wstrb[1]) unf_clr = iomem_wdata[8 +: NUM_CH];
          if (iomem_wstrb[2]) err_clr = iomem_wdata[16 +: NUM_CH];
        end
        6'd2: begin
          if (iomem_wstrb[0]) ie_ovf_d = iomem_wdata[NUM_CH-1:0];
          if (iomem_wstrb[1]) ie_unf_d = iomem_wdata[8 +: NUM_CH];
          if (iomem_wstrb[2]) ie_err_d = iomem_wdata[16 +: NUM_CH];
        end
        6'd3: begin
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (iomem_wstrb[0] && iomem_wdata[c]) snap_d[c] = count_q[c];
          end
        end
        default: begin
          // A CPU load overrides any step landing in the same cycle, flags included
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (32'(word) == 4 + c) begin
              cnt_wr                 = '0;
              cnt_wr[CNT_WIDTH-1:0]  = count_q[c];
              cnt_wr                 = (cnt_wr & ~wmask) | (iomem_wdata & wmask);
              count_d[c]             = cnt_wr[CNT_WIDTH-1:0];
              ovf_set[c]             = 1'b0;
              unf_set[c]             = 1'b0;
              err_set[c]             = 1'b0;
            end
          end
        end
      endcase
    end

    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
    unf_d = (unf_q & ~unf_clr) | unf_set;
    err_d = (err_q & ~err_clr) | err_set;
    irq_d = |((ovf_q & ie_ovf_q) | (unf_q & ie_unf_q) | (err_q & ie_err_q));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      prev_a_q <= '0;
      prev_b_q <= '0;
      en_q     <= '0;
      inv_q    <= '0;
      ovf_q    <= '0;
      unf_q    <= '0;
      err_q    <= '0;
      ie_ovf_q <= '0;
      ie_unf_q <= '0;
      ie_err_q <= '0;
      count_q  <= '0;
      snap_q   <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync_a_q <= sync_a_d;
      sync_b_q <= sync_b_d;
      prev_a_q <= prev_a_d;
      prev_b_q <= prev_b_d;
      en_q     <= en_d;
      inv_q    <= inv_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      err_q    <= err_d;
      ie_ovf_q <= ie_ovf_d;
      ie_unf_q <= ie_unf_d;
      ie_err_q <= ie_err_d;
      count_q  <= count_d;
      snap_q   <= snap_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq         = irq_q;

endmodule

// File: doc/iomem_quad_encoder.md
Name: iomem_quad_encoder

Overview:
N-channel quadrature encoder counter peripheral on the PicoSoC iomem bus. It is the parametrised successor to the fixed left/right encoder registers. Each channel does 4x decoding of A/B inputs, with per-channel enable, direction invert, atomic snapshot, sticky overflow/underflow/error flags and a maskable interrupt. It sits beside the GPIO/clock peripherals and decodes one 256-byte window of iomem space.

Parameters:
NUM_CH, 2, number of encoder channels (1..8)
CNT_WIDTH, 32, counter width in bits (8..32); read values zero-extended to 32
BASE_ADDR, 24'h030003, value matched against iomem_addr[31:8]
SYNC_STAGES, 2, synchroniser flops on enc_a/enc_b (>=2)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
iomem_valid  input  1  bus request valid
iomem_ready  output  1  one-cycle response strobe
iomem_wstrb  input  4  byte write strobes; 0 = read
iomem_addr  input  32  byte address
iomem_wdata  input  32  write data
iomem_rdata  output  32  read data, valid when iomem_ready=1
enc_a  input  NUM_CH  encoder phase A, asynchronous
enc_b  input  NUM_CH  encoder phase B, asynchronous
irq  output  1  level interrupt, registered

Behaviour:
- Reset (resetn low, async): all counters, snapshots, CTRL, STATUS, IRQ_EN, iomem_ready, iomem_rdata, irq = 0. Synchroniser and prev-state flops = 0.
- Bus: a request hits when iomem_valid && !iomem_ready && addr[31:8]==BASE_ADDR. On a hit, iomem_ready=1 and rdata is registered on the next edge. Ready is a 1-cycle pulse, so back-to-back requests take 2 cycles each. Non-hit requests get no response, and ready stays 0.
- Writes honour each byte lane of wstrb. Reads return the value before the write in the same access.
- Register map (addr[7:0]):
  - 0x00 CTRL: [7:0] enable per channel; [15:8] direction invert per channel.
  - 0x04 STATUS: [7:0] overflow, [15:8] underflow, [23:16] invalid-transition error. All sticky, write-1-to-clear.
  - 0x08 IRQ_EN: same bit layout as STATUS.
  - 0x0C SNAP: write bit ch=1 copies COUNT[ch] into SNAPSHOT[ch]. Reads 0.
  - 0x10+4*ch COUNT[ch]: read live; write loads (byte lanes).
  - 0x30+4*ch SNAPSHOT[ch]: read-only.
  - Unused offsets, and bits for channels >= NUM_CH: read 0, writes ignored, ready still returned.
- Decode per channel: s = synchronised {A,B}; p = s from the previous cycle. p is updated every cycle, including when the channel is disabled, so enabling a channel never yields a spurious step.
  - Gray sequence 00->01->11->10->00 is +1; the reverse sequence is -1; s==p is 0.
  - Both bits changing sets error[ch] and leaves the count unchanged.
  - Invert bit swaps the sign. Disabled channel: count holds and no flags are set.
- Step latency: an edge on enc_a/enc_b changes COUNT exactly SYNC_STAGES+1 cycles later.
- Arithmetic: modulo 2^CNT_WIDTH.
  - +1 from all-ones -> 0 and sets overflow[ch].
  - -1 from 0 -> all-ones and sets underflow[ch].
- Simultaneous events:
  - CPU COUNT write vs step, same cycle: the write wins and the step is dropped, with no flag.
  - W1C vs new flag event on the same bit: set wins.
  - SNAP vs step: the snapshot captures the pre-step value.
  - Multiple channels step independently in the same cycle.
- irq = registered |(STATUS & IRQ_EN). It rises one cycle after the flag sets and falls one cycle after the clear.
- Reset mid-transaction: ready drops immediately and the pending access is lost. Software re-issues it.

Test Plan:
- Reset, then read 0x00/0x04/0x10 -> rdata 0, ready pulses exactly 1 cycle, irq=0. Access at addr 0x03000400 -> no ready.
- CTRL=0x01; drive ch0 AB 00,01,11,10,00 (forward, 4 edges) -> COUNT[0]=4, each change 3 cycles after its edge (SYNC_STAGES=2). Reverse 4 edges -> 0. Set CTRL=0x0101 and repeat forward -> 0xFFFFFFFC, underflow[0] set.
- Write COUNT[1]=0xFFFFFFFF, CTRL=0x02, IRQ_EN=0x02, one forward step -> COUNT[1]=0, STATUS=0x00000002, irq=1. Write STATUS=0x2 -> STATUS=0, irq=0 next cycle.
- ch0 enabled, AB jumps 00->11 -> STATUS[16]=1, count unchanged. Disabled channel with toggling inputs -> count holds. Enable it while inputs are static -> no step.
- COUNT[0]=100; a SNAP=0x1 write coincides with a forward step -> SNAPSHOT[0]=100, COUNT[0]=101. A COUNT write of 5 coinciding with a step -> 5.
- wstrb=0b0010 write of 0x0000AB00 to COUNT[0]=0x11223344 -> 0x1122AB44. Assert resetn low mid-count -> all registers 0 asynchronously.
